gpio_mul_sched: RTL and testbench
=================================

# gpio_mul_sched

Bus-side controller that sequences the GPIO emulator's multiply-and-popcount datapath. Accepts operands and a start command over the emulator's strobed register bus, drives an iterative shift-add multiplier sub-module, then counts ones in the product, and publishes result, ones count and status. Replaces free-running, edge-triggered sequencing with a single-clock FSM and a defined start/busy/done handshake.

## Interface

- `A_W`, 24: operand width.
- `R_W`, 32: published result width (low bits of product).
- `BASE`, 16'h0380: register block base address.

- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `saddress` in 16: register address, valid while `srd`/`swr` high.
- `srd` in 1: read strobe, one-cycle pulse.
- `swr` in 1: write strobe, one-cycle pulse.
- `sdata_in` in 32: write data.
- `sdata_out` out 32: read data, registered.
- `gpio_out` out 32: `{16'h0, start_count[15:0]}`.

## Operation

- Register map, offsets from `BASE`:
  - +0x00 A1 (RW, 24b).
  - +0x08 A2 (RW, 24b).
  - +0x10 W (RO, 32b).
  - +0x18 L (RO, 24b, zero-extended).
  - +0x20 CTRL/STATUS.
- CTRL write: bit0 = start.
- STATUS read: bit0 busy, bit1 done, bit2 valid, bit3 err (sticky); other bits 0.
- FSM states:
  - IDLE: start with busy=0 → latch A1/A2 into working regs, clear done, increment `start_count` (16b, wraps 0xFFFF→0), go to MUL.
  - MUL: 24 cycles, one multiplier bit per cycle → POPC.
  - POPC: 32 cycles, one product bit per cycle → DONE.
  - DONE: 1 cycle; commit W = product[31:0], L = ones, valid = (product[47:32]==0); set done → IDLE.
- Arithmetic: product is 48b unsigned; no truncation before commit. L range 0..32.
- Start while busy is ignored and sets err; no restart, count unchanged. Err clears only on write of CTRL with bit3=1 (write-1-to-clear), which may be combined with start.
- A1/A2 writes during busy update the registers but not the running job.
- W, L and valid hold the last committed job until the next DONE; reads during busy return old values.
- Writes to W/L are ignored. Unmapped reads return 0; unmapped writes have no effect.
- `srd` and `swr` in the same cycle are both serviced; the read returns pre-write contents.

## Timing

- Reset: `sdata_out`=0, `gpio_out`=0, A1=A2=W=L=0, STATUS=0, FSM=IDLE. Reset mid-job aborts it with no commit.
- Read latency: `srd` sampled at edge N, data on `sdata_out` after edge N; held until the next `srd`.
- Start latency: `swr` start at edge 0 → busy=1 after edge 0. MUL occupies cycles 1–24, POPC 25–56, DONE 57. After edge 57: busy=0, done=1, W/L/valid updated. A start accepted at edge 58 is legal (back-to-back).
- STATUS read on the same edge as the commit returns pre-commit status.
- `gpio_out` updates after the edge that accepts start.

## Structure

- Package `gpio_mul_pkg`: register offsets, STATUS bit indices, FSM state enum, `A_W`/`R_W` defaults.
- Sub-module `mul_shift_add`: start/busy/done 24-cycle iterative multiplier with a 48b output. The controller owns FSM, registers and popcount shifter.

## Test plan

- Reset, then read all five registers → all 0. Then `gpio_out`=0.
- A1=3, A2=5, start; poll STATUS → busy for 57 cycles. Then W=15, L=4, STATUS=0b0110. Then `gpio_out`=1.
- A1=0xFFFFFF, A2=0xFFFFFF → W=0xFE000001, L=8, valid=0.
- Start, then start again at cycle 10 → second ignored, err=1, `gpio_out`=1. Result is for the first operands. Write CTRL=0x8 → err=0.
- Write A1=7 during busy → running job's result is unchanged. Next start uses A1=7.
- Assert `reset` at cycle 30 of a job → STATUS=0, W=0, FSM IDLE. A new start completes normally.

Source files
------------

// File: rtl/gpio_mul_pkg.sv
// Shared constants for the GPIO multiply-and-popcount controller:
// register offsets, STATUS/CTRL bit positions, FSM states, default widths.
package gpio_mul_pkg;

  localparam int A_W_DEF = 24;
  localparam int R_W_DEF = 32;

  localparam logic [7:0] OFF_A1   = 8'h00;
  localparam logic [7:0] OFF_A2   = 8'h08;
  localparam logic [7:0] OFF_W    = 8'h10;
  localparam logic [7:0] OFF_L    = 8'h18;
  localparam logic [7:0] OFF_CTRL = 8'h20;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_VALID = 2;
  localparam int ST_ERR   = 3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ERR_CLR = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_POPC,
    S_DONE
  } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle,
// A_W cycles after the start edge, full 2*A_W-bit product.
module mul_shift_add import gpio_mul_pkg::*; #(
  parameter int A_W = A_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [A_W-1:0]   a,
  input  logic [A_W-1:0]   b,
  output logic             busy,
  output logic             done,
  output logic [2*A_W-1:0] product
);

  localparam int P_W = 2 * A_W;
  localparam int C_W = $clog2(A_W);

  logic [P_W-1:0] acc;
  logic [P_W-1:0] mcand;
  logic [A_W-1:0] mplier;
  logic [C_W-1:0] cnt;
  logic           active;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start && !active) begin
      acc    <= '0;
      mcand  <= {{A_W{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == C_W'(A_W - 1)) active <= 1'b0;
    end
  end

  // done marks the cycle whose closing edge performs the final step, so the
  // caller can move on exactly as the product settles.
  assign busy    = active;
  assign done    = active && (cnt == C_W'(A_W - 1));
  assign product = acc;

endmodule

// File: rtl/gpio_mul_sched.sv
// Register-bus controller: latches operands, runs the shift-add multiplier,
// popcounts the low product word bit by bit, then commits W/L/valid.
module gpio_mul_sched import gpio_mul_pkg::*; #(
  parameter int          A_W  = A_W_DEF,
  parameter int          R_W  = R_W_DEF,
  parameter logic [15:0] BASE = 16'h0380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  output logic [31:0] gpio_out
);

  localparam int P_W = 2 * A_W;
  localparam int L_W = $clog2(R_W + 1);
  localparam int I_W = $clog2(R_W);

  state_t         state, state_nxt;
  logic [A_W-1:0] a1, a2;
  logic [R_W-1:0] w_reg;
  logic [L_W-1:0] l_reg, ones;
  logic [I_W-1:0] idx;
  logic           valid_f, done_f, err_f;
  logic [15:0]    start_count;
  logic           busy, mul_start, mul_busy, mul_done;
  logic [P_W-1:0] product;
  logic [31:0]    rdata;

  logic sel_a1, sel_a2, sel_w, sel_l, sel_ctrl;
  logic wr_ctrl, start_req;
  logic unused_bits;

  assign sel_a1   = (saddress == BASE + 16'(OFF_A1));
  assign sel_a2   = (saddress == BASE + 16'(OFF_A2));
  assign sel_w    = (saddress == BASE + 16'(OFF_W));
  assign sel_l    = (saddress == BASE + 16'(OFF_L));
  assign sel_ctrl = (saddress == BASE + 16'(OFF_CTRL));

  assign wr_ctrl     = swr && sel_ctrl;
  assign start_req   = wr_ctrl && sdata_in[CTRL_START];
  assign unused_bits = ^{sdata_in[31:A_W], sdata_in[2:1]};

  mul_shift_add #(.A_W(A_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a1),
    .b       (a2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (mul_start) state_nxt = S_MUL;
      S_MUL:  if (mul_done) state_nxt = S_POPC;
      S_POPC: if (idx == I_W'(R_W - 1)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The multiplier captures A1/A2 on this pulse; those are the job's working
  // operands, so later A1/A2 writes cannot disturb a running job.
  always_comb begin
    busy      = (state != S_IDLE);
    mul_start = (state == S_IDLE) && start_req && !mul_busy;
  end

  always_comb begin
    rdata = '0;
    if (sel_a1)   rdata[A_W-1:0] = a1;
    if (sel_a2)   rdata[A_W-1:0] = a2;
    if (sel_w)    rdata[R_W-1:0] = w_reg;
    if (sel_l)    rdata[L_W-1:0] = l_reg;
    if (sel_ctrl) begin
      rdata[ST_BUSY]  = busy;
      rdata[ST_DONE]  = done_f;
      rdata[ST_VALID] = valid_f;
      rdata[ST_ERR]   = err_f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a1          <= '0;
      a2          <= '0;
      w_reg       <= '0;
      l_reg       <= '0;
      ones        <= '0;
      idx         <= '0;
      valid_f     <= 1'b0;
      done_f      <= 1'b0;
      err_f       <= 1'b0;
      start_count <= '0;
      sdata_out   <= '0;
    end else begin
      if (swr && sel_a1) a1 <= sdata_in[A_W-1:0];
      if (swr && sel_a2) a2 <= sdata_in[A_W-1:0];

      if (mul_start) begin
        done_f      <= 1'b0;
        start_count <= start_count + 16'd1;
        ones        <= '0;
        idx         <= '0;
      end

      // A rejected start takes precedence over a same-write clear.
      if (start_req && busy)                      err_f <= 1'b1;
      else if (wr_ctrl && sdata_in[CTRL_ERR_CLR]) err_f <= 1'b0;

      if (state == S_POPC) begin
        ones <= ones + L_W'(product[idx]);
        idx  <= idx + 1'b1;
      end

      if (state == S_DONE) begin
        w_reg   <= product[R_W-1:0];
        l_reg   <= ones;
        valid_f <= ~|product[P_W-1:R_W];
        done_f  <= 1'b1;
      end

      if (srd) sdata_out <= rdata;
    end
  end

  assign gpio_out = {16'h0, start_count};

endmodule

// File: tb/tb_gpio_mul_sched.sv
// Directed bench: reads push expected data into a queue, a monitor pops and
// compares one cycle after each sampled read strobe.
module tb_gpio_mul_sched;
  import gpio_mul_pkg::*;

  localparam logic [15:0] BASE = 16'h0380;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [15:0] saddress = '0;
  logic [31:0] sdata_in = '0;
  logic [31:0] sdata_out;
  logic [31:0] gpio_out;

  int          checks = 0;
  int          errors = 0;
  logic        rd_pend = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  gpio_mul_sched #(.A_W(24), .R_W(32), .BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .saddress  (saddress),
    .srd       (srd),
    .swr       (swr),
    .sdata_in  (sdata_in),
    .sdata_out (sdata_out),
    .gpio_out  (gpio_out)
  );

  function automatic logic [15:0] ad(input logic [7:0] off);
    return BASE + {8'h00, off};
  endfunction

  // All tasks start and end positioned at a falling edge.
  task automatic rd(input logic [15:0] a, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    srd = 1'b1;
    saddress = a;
    @(negedge clk);
    srd = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    swr = 1'b1;
    saddress = a;
    sdata_in = d;
    @(negedge clk);
    swr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_gpio(input logic [31:0] e, input string n);
    checks++;
    if (gpio_out !== e) begin
      errors++;
      $display("FAIL %s gpio_out got %h want %h", n, gpio_out, e);
    end
  endtask

  always @(posedge clk) rd_pend <= srd;

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    string       n;
    if (rd_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read got %h want none", sdata_out);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (sdata_out !== e) begin
          errors++;
          $display("FAIL %s got %h want %h", n, sdata_out, e);
        end
      end
    end
  end

  initial begin
    idle(3);
    reset = 1'b0;

    // Reset state
    rd(ad(OFF_A1), 32'h0, "rst_a1");
    rd(ad(OFF_A2), 32'h0, "rst_a2");
    rd(ad(OFF_W), 32'h0, "rst_w");
    rd(ad(OFF_L), 32'h0, "rst_l");
    rd(ad(OFF_CTRL), 32'h0, "rst_status");
    chk_gpio(32'h0, "rst_gpio");

    // 3*5: busy for exactly 57 sampled reads, then done+valid
    wr(ad(OFF_A1), 32'd3);
    wr(ad(OFF_A2), 32'd5);
    wr(ad(OFF_CTRL), 32'h1);
    for (int i = 0; i < 57; i++) rd(ad(OFF_CTRL), 32'h1, "busy_poll");
    rd(ad(OFF_CTRL), 32'h6, "status_done");
    rd(ad(OFF_W), 32'd15, "w_3x5");
    rd(ad(OFF_L), 32'd4, "l_3x5");
    chk_gpio(32'h1, "gpio_job1");

    // Writes to W are ignored; unmapped reads return 0
    wr(ad(OFF_W), 32'h1234_5678);
    rd(ad(OFF_W), 32'd15, "w_ro");
    rd(ad(8'h04), 32'h0, "unmapped");
    rd(ad(OFF_A1), 32'd3, "a1_readback");

    // Max operands: 48-bit product, upper bits nonzero
    wr(ad(OFF_A1), 32'h00FF_FFFF);
    wr(ad(OFF_A2), 32'h00FF_FFFF);
    wr(ad(OFF_CTRL), 32'h1);
    idle(60);
    rd(ad(OFF_CTRL), 32'h2, "status_max");
    rd(ad(OFF_W), 32'hFE00_0001, "w_max");
    rd(ad(OFF_L), 32'd8, "l_max");
    chk_gpio(32'h2, "gpio_job2");

    // Start while busy: ignored, err set, count unchanged
    wr(ad(OFF_A1), 32'd2);
    wr(ad(OFF_A2), 32'd9);
    wr(ad(OFF_CTRL), 32'h1);
    idle(9);
    wr(ad(OFF_CTRL), 32'h1);
    rd(ad(OFF_CTRL), 32'h9, "status_err_busy");
    chk_gpio(32'h3, "gpio_restart_ignored");
    idle(60);
    rd(ad(OFF_CTRL), 32'hE, "status_err_done");
    rd(ad(OFF_W), 32'd18, "w_2x9");
    rd(ad(OFF_L), 32'd2, "l_2x9");
    wr(ad(OFF_CTRL), 32'h8);
    rd(ad(OFF_CTRL), 32'h6, "status_err_clr");

    // A1 write during busy does not affect the running job
    wr(ad(OFF_A1), 32'd4);
    wr(ad(OFF_A2), 32'd6);
    wr(ad(OFF_CTRL), 32'h1);
    idle(5);
    wr(ad(OFF_A1), 32'd7);
    rd(ad(OFF_W), 32'd18, "w_old_during_busy");
    idle(60);
    rd(ad(OFF_W), 32'd24, "w_4x6");
    rd(ad(OFF_L), 32'd2, "l_4x6");
    rd(ad(OFF_A1), 32'd7, "a1_updated");
    wr(ad(OFF_CTRL), 32'h1);
    idle(60);
    rd(ad(OFF_W), 32'd42, "w_7x6");
    rd(ad(OFF_L), 32'd3, "l_7x6");
    chk_gpio(32'h5, "gpio_job5");

    // Reset mid-job aborts with no commit
    wr(ad(OFF_A2), 32'h1F);
    wr(ad(OFF_CTRL), 32'h1);
    idle(29);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd(ad(OFF_CTRL), 32'h0, "status_after_rst");
    rd(ad(OFF_W), 32'h0, "w_after_rst");
    rd(ad(OFF_L), 32'h0, "l_after_rst");
    rd(ad(OFF_A1), 32'h0, "a1_after_rst");
    chk_gpio(32'h0, "gpio_after_rst");

    // Fresh job after reset, plus zero operand boundary
    wr(ad(OFF_A1), 32'd3);
    wr(ad(OFF_A2), 32'd5);
    wr(ad(OFF_CTRL), 32'h1);
    idle(60);
    rd(ad(OFF_CTRL), 32'h6, "status_post_rst_job");
    rd(ad(OFF_W), 32'd15, "w_post_rst_job");
    rd(ad(OFF_L), 32'd4, "l_post_rst_job");
    chk_gpio(32'h1, "gpio_post_rst_job");
    wr(ad(OFF_A1), 32'd0);
    wr(ad(OFF_CTRL), 32'h1);
    idle(60);
    rd(ad(OFF_W), 32'd0, "w_zero");
    rd(ad(OFF_L), 32'd0, "l_zero");
    rd(ad(OFF_CTRL), 32'h6, "status_zero");

    idle(2);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
